sys_ctrl_param: RTL and testbench
=================================

Name: sys_ctrl_param

Overview:
Parametrised command controller between the UART RX deserialiser, register file, ALU and the TX async FIFO. It decodes command frames, sequences register writes and reads, ALU operations and a new burst-read command, and pushes response frames into the TX FIFO. It back-pressures on FIFO_FULL by stalling instead of dropping frames, and it waits on the valid handshakes with a timeout.

Parameters:
DW, 8, data/frame width in bits
AW, 4, register file address width
FW, 4, ALU function code width
TO_CYC, 255, max cycles to wait for RD_DATA_VLD / ALU_OUT_VLD (>=1)
CMD_WR, 8'hAA, register write command
CMD_RD, 8'hBB, register read command
CMD_ALU, 8'hCC, ALU op with operands
CMD_NOP, 8'hDD, ALU op without operands
CMD_BRD, 8'hEE, burst register read

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
RX_P_DATA  in  DW  received frame
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
ALU_OUT  in  2*DW  ALU result
ALU_OUT_VLD  in  1  ALU result valid
RD_DATA  in  DW  register file read data
RD_DATA_VLD  in  1  read data valid
FIFO_FULL  in  1  TX FIFO full
ALU_FUN  out  FW  ALU function code
ALU_EN  out  1  ALU enable
CLK_EN  out  1  ALU clock-gate enable
ADDR  out  AW  register file address
WR_EN  out  1  register write strobe
RD_EN  out  1  register read strobe
WR_DATA  out  DW  register write data
TX_P_DATA  out  DW  frame to TX FIFO
TX_D_VLD  out  1  TX FIFO write strobe
CLK_DIV_EN  out  1  clock divider enable
BUSY  out  1  high in every state except IDLE
ERR  out  1  one-cycle pulse on illegal command, zero count or timeout

Behaviour:
- Reset: state IDLE. All outputs 0 except CLK_DIV_EN=1. Internal counters and latches cleared. CLK_DIV_EN is constantly 1 out of reset.
- All outputs are registered except TX_D_VLD = (state in PUSH_*) & !FIFO_FULL. TX_P_DATA is registered and stable for the whole PUSH_* state.
- Frames are consumed only on RX_D_VLD, and only in IDLE, WR_ADDR, WR_DATA, RD_ADDR, BRD_ADDR, BRD_CNT, OPA, OPB and FUN. RX_D_VLD in any other state is ignored.
- IDLE: a command frame selects the next state:
  - CMD_WR -> WR_ADDR
  - CMD_RD -> RD_ADDR
  - CMD_ALU -> OPA
  - CMD_NOP -> FUN
  - CMD_BRD -> BRD_ADDR
  - any other value -> ERR pulse, stay IDLE.
- WR_ADDR: latch ADDR=RX_P_DATA[AW-1:0]. WR_DATA: on the next frame, WR_EN=1 for exactly one cycle with WR_DATA=frame, then IDLE.
- RD_ADDR: latch ADDR, count N=1 -> RD_REQ.
- BRD_ADDR: latch ADDR. BRD_CNT: N=RX_P_DATA. N==0 gives an ERR pulse and returns to IDLE; otherwise -> RD_REQ.
- RD_REQ: RD_EN=1 for one cycle -> RD_WAIT.
- RD_WAIT: on RD_DATA_VLD, latch RD_DATA -> PUSH_RD. If TO_CYC cycles pass without valid, ERR pulse and IDLE.
- PUSH_RD: hold until !FIFO_FULL. Then write one frame, decrement N. If N becomes 0 -> IDLE; else ADDR = ADDR+1 mod 2^AW (wraps) -> RD_REQ.
- OPA / OPB: WR_EN one cycle with ADDR=0 (OPA) or ADDR=1 (OPB) and WR_DATA=frame. OPB -> FUN.
- FUN: latch ALU_FUN=RX_P_DATA[FW-1:0], assert ALU_EN=CLK_EN=1 -> ALU_WAIT.
- ALU_WAIT: ALU_EN and CLK_EN stay high. On ALU_OUT_VLD, latch ALU_OUT, drop ALU_EN and CLK_EN next cycle -> PUSH_LO. Timeout behaves as in RD_WAIT.
- Result push: PUSH_LO pushes ALU_OUT[DW-1:0] and PUSH_HI pushes ALU_OUT[2DW-1:DW]. Both frames are always sent, LSB first. Each push stalls while FIFO_FULL.
- Timeout counter clears on every state change.
- FIFO_FULL deasserting mid-stall: the push occurs that same cycle. No frame is ever lost or duplicated.
- Async reset mid-operation aborts immediately to reset values; no partial pushes complete.
- BUSY=1 in every state except IDLE.

Test Plan:
- AA,05,3C -> exactly one WR_EN pulse with ADDR=5, WR_DATA=0x3C; no TX_D_VLD; BUSY back to 0.
- BB,07 with RD_DATA=0x5A valid 2 cycles after RD_EN -> one RD_EN with ADDR=7; one TX frame 0x5A.
- CC,10,20,00 with ALU_OUT=0x1234 valid after 3 cycles -> writes 0x10@0 and 0x20@1; ALU_FUN=0; TX frames 0x34 then 0x12.
- EE,0E,03 with FIFO_FULL held 10 cycles during the 2nd push -> reads at 0xE,0xF,0x0 (wrap); exactly 3 frames in order; no loss or duplication.
- Command 0x42, then EE,00,00 -> two ERR pulses; state IDLE; no strobes.
- BB,03 with RD_DATA_VLD never asserted -> ERR pulse after TO_CYC cycles, then IDLE; RST low mid-ALU_WAIT gives reset values next edge.

Source files
------------

// File: rtl/sys_ctrl_param_if.sv
// Bus bundle between the command controller and its neighbours: the UART RX
// deserialiser, the register file, the ALU and the TX async FIFO.
// The master side is the controller; the slave side is the surrounding system.
interface sys_ctrl_param_if #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int FW = 4
);
  // RX deserialiser
  logic [DW-1:0]   RX_P_DATA;
  logic            RX_D_VLD;
  // ALU
  logic [2*DW-1:0] ALU_OUT;
  logic            ALU_OUT_VLD;
  logic [FW-1:0]   ALU_FUN;
  logic            ALU_EN;
  logic            CLK_EN;
  // Register file
  logic [DW-1:0]   RD_DATA;
  logic            RD_DATA_VLD;
  logic [AW-1:0]   ADDR;
  logic            WR_EN;
  logic            RD_EN;
  logic [DW-1:0]   WR_DATA;
  // TX FIFO
  logic            FIFO_FULL;
  logic [DW-1:0]   TX_P_DATA;
  logic            TX_D_VLD;
  // Misc status / control
  logic            CLK_DIV_EN;
  logic            BUSY;
  logic            ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, RD_DATA, RD_DATA_VLD,
           FIFO_FULL,
    output ALU_FUN, ALU_EN, CLK_EN, ADDR, WR_EN, RD_EN, WR_DATA, TX_P_DATA,
           TX_D_VLD, CLK_DIV_EN, BUSY, ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, ALU_OUT, ALU_OUT_VLD, RD_DATA, RD_DATA_VLD,
           FIFO_FULL,
    input  ALU_FUN, ALU_EN, CLK_EN, ADDR, WR_EN, RD_EN, WR_DATA, TX_P_DATA,
           TX_D_VLD, CLK_DIV_EN, BUSY, ERR
  );
endinterface

// File: rtl/sys_ctrl_param.sv
// Command controller: decodes RX command frames, sequences register-file
// writes/reads (single and burst), ALU operations, and pushes response
// frames into the TX FIFO. Pushes stall on FIFO_FULL; read/ALU handshakes
// are bounded by a timeout that raises a one-cycle ERR pulse.
module sys_ctrl_param #(
  parameter int              DW      = 8,
  parameter int              AW      = 4,
  parameter int              FW      = 4,
  parameter int              TO_CYC  = 255,
  parameter logic [DW-1:0]   CMD_WR  = DW'(8'hAA),
  parameter logic [DW-1:0]   CMD_RD  = DW'(8'hBB),
  parameter logic [DW-1:0]   CMD_ALU = DW'(8'hCC),
  parameter logic [DW-1:0]   CMD_NOP = DW'(8'hDD),
  parameter logic [DW-1:0]   CMD_BRD = DW'(8'hEE)
) (
  input  logic             CLK,
  input  logic             RST,
  sys_ctrl_param_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_BRD_ADDR,
    S_BRD_CNT,
    S_RD_REQ,
    S_RD_WAIT,
    S_PUSH_RD,
    S_OPA,
    S_OPB,
    S_FUN,
    S_ALU_WAIT,
    S_PUSH_LO,
    S_PUSH_HI
  } state_t;

  // Timeout counter counts cycles spent in a wait state: 0 .. TO_CYC-1.
  localparam int             TOW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYC - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [FW-1:0]   alu_fun_q, alu_fun_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic [DW-1:0]   alu_hi_q, alu_hi_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [TOW-1:0]  to_cnt_q, to_cnt_d;
  logic            wr_en_q, wr_en_d;
  logic            err_q, err_d;
  logic            rd_en_q;
  logic            alu_en_q;
  logic            busy_q;
  logic            clk_div_en_q;

  logic [DW-1:0]   frame;
  logic            frame_vld;
  logic            push_ok;
  logic            timeout;
  logic            in_wait;
  logic            in_push;

  assign frame     = bus.RX_P_DATA;
  assign frame_vld = bus.RX_D_VLD;
  assign push_ok   = ~bus.FIFO_FULL;
  assign timeout   = (to_cnt_q == TO_LAST);
  assign in_wait   = (state_q == S_RD_WAIT) || (state_q == S_ALU_WAIT);
  assign in_push   = (state_q == S_PUSH_RD) || (state_q == S_PUSH_LO) ||
                     (state_q == S_PUSH_HI);

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      state_q <= state_d;
    end
  end

  // Next-state decode and next values of every registered output / latch.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    tx_data_d = tx_data_q;
    alu_hi_d  = alu_hi_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_vld) begin
          case (frame)
            CMD_WR:  state_d = S_WR_ADDR;
            CMD_RD:  state_d = S_RD_ADDR;
            CMD_ALU: state_d = S_OPA;
            CMD_NOP: state_d = S_FUN;
            CMD_BRD: state_d = S_BRD_ADDR;
            default: err_d   = 1'b1;
          endcase
        end
      end

      S_WR_ADDR: begin
        if (frame_vld) begin
          addr_d  = frame[AW-1:0];
          state_d = S_WR_DATA;
        end
      end

      S_WR_DATA: begin
        if (frame_vld) begin
          wr_en_d   = 1'b1;
          wr_data_d = frame;
          state_d   = S_IDLE;
        end
      end

      S_RD_ADDR: begin
        if (frame_vld) begin
          addr_d  = frame[AW-1:0];
          cnt_d   = DW'(1);
          state_d = S_RD_REQ;
        end
      end

      S_BRD_ADDR: begin
        if (frame_vld) begin
          addr_d  = frame[AW-1:0];
          state_d = S_BRD_CNT;
        end
      end

      S_BRD_CNT: begin
        if (frame_vld) begin
          if (frame == '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = frame;
            state_d = S_RD_REQ;
          end
        end
      end

      // RD_EN is high for the single cycle spent here.
      S_RD_REQ: state_d = S_RD_WAIT;

      S_RD_WAIT: begin
        if (bus.RD_DATA_VLD) begin
          tx_data_d = bus.RD_DATA;
          state_d   = S_PUSH_RD;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_PUSH_RD: begin
        if (push_ok) begin
          cnt_d = cnt_q - DW'(1);
          if (cnt_q == DW'(1)) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = S_RD_REQ;
          end
        end
      end

      S_OPA: begin
        if (frame_vld) begin
          wr_en_d   = 1'b1;
          addr_d    = '0;
          wr_data_d = frame;
          state_d   = S_OPB;
        end
      end

      S_OPB: begin
        if (frame_vld) begin
          wr_en_d   = 1'b1;
          addr_d    = AW'(1);
          wr_data_d = frame;
          state_d   = S_FUN;
        end
      end

      S_FUN: begin
        if (frame_vld) begin
          alu_fun_d = frame[FW-1:0];
          state_d   = S_ALU_WAIT;
        end
      end

      S_ALU_WAIT: begin
        if (bus.ALU_OUT_VLD) begin
          tx_data_d = bus.ALU_OUT[DW-1:0];
          alu_hi_d  = bus.ALU_OUT[2*DW-1:DW];
          state_d   = S_PUSH_LO;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      // Low byte goes first; the high byte is staged into TX_P_DATA on exit.
      S_PUSH_LO: begin
        if (push_ok) begin
          tx_data_d = alu_hi_q;
          state_d   = S_PUSH_HI;
        end
      end

      S_PUSH_HI: begin
        if (push_ok) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Timeout counter: restarts on every state change, only runs in wait states.
  always_comb begin
    to_cnt_d = '0;
    if (in_wait && (state_d == state_q)) to_cnt_d = to_cnt_q + TOW'(1);
  end

  // Registered outputs and datapath latches. Strobes that are tied to a
  // state (RD_EN, ALU_EN/CLK_EN, BUSY) are registered from the next state so
  // they are high exactly while the FSM sits in that state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q       <= '0;
      wr_data_q    <= '0;
      alu_fun_q    <= '0;
      tx_data_q    <= '0;
      alu_hi_q     <= '0;
      cnt_q        <= '0;
      to_cnt_q     <= '0;
      wr_en_q      <= 1'b0;
      err_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      alu_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      clk_div_en_q <= 1'b1;
    end else begin
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      alu_fun_q    <= alu_fun_d;
      tx_data_q    <= tx_data_d;
      alu_hi_q     <= alu_hi_d;
      cnt_q        <= cnt_d;
      to_cnt_q     <= to_cnt_d;
      wr_en_q      <= wr_en_d;
      err_q        <= err_d;
      rd_en_q      <= (state_d == S_RD_REQ);
      alu_en_q     <= (state_d == S_ALU_WAIT);
      busy_q       <= (state_d != S_IDLE);
      clk_div_en_q <= 1'b1;
    end
  end

  assign bus.ALU_FUN    = alu_fun_q;
  assign bus.ALU_EN     = alu_en_q;
  assign bus.CLK_EN     = alu_en_q;
  assign bus.ADDR       = addr_q;
  assign bus.WR_EN      = wr_en_q;
  assign bus.RD_EN      = rd_en_q;
  assign bus.WR_DATA    = wr_data_q;
  assign bus.TX_P_DATA  = tx_data_q;
  // The FIFO write strobe is the only combinational output: it must drop in
  // the same cycle FIFO_FULL rises so no frame is written into a full FIFO.
  assign bus.TX_D_VLD   = in_push & ~bus.FIFO_FULL;
  assign bus.CLK_DIV_EN = clk_div_en_q;
  assign bus.BUSY       = busy_q;
  assign bus.ERR        = err_q;

endmodule

// File: tb/tb_sys_ctrl_param.sv
// Self-checking bench for sys_ctrl_param. A behavioural register file, ALU
// and TX FIFO surround the DUT; a command-level reference model predicts the
// TX frames, register writes, read addresses and ERR pulses of each command.
module tb_sys_ctrl_param;
  localparam int DW = 8, AW = 4, FW = 4, TO_CYC = 255;
  localparam logic [7:0] CMD_WR = 8'hAA, CMD_RD = 8'hBB, CMD_ALU = 8'hCC,
                         CMD_NOP = 8'hDD, CMD_BRD = 8'hEE;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  sys_ctrl_param_if #(.DW(DW), .AW(AW), .FW(FW)) bus ();
  sys_ctrl_param #(.DW(DW), .AW(AW), .FW(FW), .TO_CYC(TO_CYC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Environment state
  logic [7:0]  env_mem [16];
  logic [7:0]  ref_mem [16];
  logic [7:0]  cmd_q   [$];
  logic [7:0]  got_tx  [$];
  logic [7:0]  exp_tx  [$];
  logic [11:0] got_wr  [$];
  logic [11:0] exp_wr  [$];
  logic [3:0]  got_rd  [$];
  logic [3:0]  exp_rd  [$];
  int   got_err = 0, exp_err = 0;
  int   rd_delay = 0, alu_delay = 0, rd_lat = 0;
  bit   rd_mute = 0, alu_mute = 0;
  int   fifo_mode = 0, stall_cnt = 0;
  bit   stall_armed = 0;
  int   cyc = 0, rd_en_cyc = 0, err_cyc = 0, full_viol = 0;
  bit   alu_en_prev = 0;
  logic [3:0] rd_addr_lat = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural ALU used by both the environment and the reference model.
  function automatic logic [15:0] alu_f(input logic [3:0] fun, input logic [7:0] a,
                                        input logic [7:0] b);
    case (fun)
      4'd0:    return 16'(a) * 16'(b);
      4'd1:    return 16'(a) + 16'(b);
      4'd2:    return 16'(a) - 16'(b);
      4'd3:    return {a & b, a | b};
      default: return {a ^ b, b};
    endcase
  endfunction

  // Monitor: samples DUT outputs on the falling edge.
  initial forever begin
    @(negedge CLK);
    cyc++;
    if (RST) begin
      if (bus.TX_D_VLD) begin
        got_tx.push_back(bus.TX_P_DATA);
        if (bus.FIFO_FULL) full_viol++;
        if (fifo_mode == 2 && stall_armed) begin
          stall_cnt   = 10;
          stall_armed = 0;
        end
      end
      if (bus.WR_EN) begin
        got_wr.push_back({bus.ADDR, bus.WR_DATA});
        env_mem[bus.ADDR] = bus.WR_DATA;
      end
      if (bus.RD_EN) begin
        got_rd.push_back(bus.ADDR);
        rd_addr_lat = bus.ADDR;
        rd_en_cyc   = cyc;
        if (!rd_mute) rd_delay = (rd_lat > 0) ? rd_lat : int'($urandom_range(1, 3));
      end
      if (bus.ERR) begin
        got_err++;
        err_cyc = cyc;
      end
      if (bus.ALU_EN && !alu_en_prev && !alu_mute) alu_delay = int'($urandom_range(1, 4));
    end
    alu_en_prev = bus.ALU_EN;
  end

  // Environment responders: register file, ALU and TX FIFO back-pressure.
  initial forever begin
    @(posedge CLK);
    #1;
    bus.RD_DATA_VLD = 1'b0;
    bus.ALU_OUT_VLD = 1'b0;
    if (rd_delay > 0) begin
      rd_delay--;
      if (rd_delay == 0) begin
        bus.RD_DATA     = env_mem[rd_addr_lat];
        bus.RD_DATA_VLD = 1'b1;
      end
    end
    if (alu_delay > 0) begin
      alu_delay--;
      if (alu_delay == 0) begin
        bus.ALU_OUT     = alu_f(bus.ALU_FUN, env_mem[0], env_mem[1]);
        bus.ALU_OUT_VLD = 1'b1;
      end
    end
    case (fifo_mode)
      1:       bus.FIFO_FULL = ($urandom_range(0, 3) == 0);
      2: begin
        if (stall_cnt > 0) begin
          bus.FIFO_FULL = 1'b1;
          stall_cnt--;
        end else begin
          bus.FIFO_FULL = 1'b0;
        end
      end
      default: bus.FIFO_FULL = 1'b0;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_cmd(input int n, input logic [7:0] f0, input logic [7:0] f1,
                         input logic [7:0] f2, input logic [7:0] f3);
    cmd_q.delete();
    cmd_q.push_back(f0);
    if (n > 1) cmd_q.push_back(f1);
    if (n > 2) cmd_q.push_back(f2);
    if (n > 3) cmd_q.push_back(f3);
  endtask

  task automatic send_frame(input logic [7:0] f);
    bus.RX_P_DATA = f;
    bus.RX_D_VLD  = 1'b1;
    tick(1);
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = 8'($urandom);
  endtask

  // Reference model: expected effects of the whole command in cmd_q.
  // no_resp: the read/ALU handshake is never answered (read -> timeout ERR,
  // ALU -> aborted by reset, so only the operand writes remain).
  task automatic model_cmd(input bit no_resp);
    logic [7:0]  c, f1, f2, f3;
    logic [3:0]  a;
    logic [15:0] r;
    c  = cmd_q[0];
    f1 = (cmd_q.size() > 1) ? cmd_q[1] : 8'h00;
    f2 = (cmd_q.size() > 2) ? cmd_q[2] : 8'h00;
    f3 = (cmd_q.size() > 3) ? cmd_q[3] : 8'h00;
    if (c == CMD_WR) begin
      a = f1[3:0];
      ref_mem[a] = f2;
      exp_wr.push_back({a, f2});
    end else if (c == CMD_RD) begin
      a = f1[3:0];
      exp_rd.push_back(a);
      if (no_resp) exp_err++;
      else exp_tx.push_back(ref_mem[a]);
    end else if (c == CMD_BRD) begin
      if (f2 == 8'h00) exp_err++;
      for (int i = 0; i < int'(f2); i++) begin
        a = 4'((int'(f1[3:0]) + i) % 16);
        exp_rd.push_back(a);
        exp_tx.push_back(ref_mem[a]);
      end
    end else if (c == CMD_ALU) begin
      ref_mem[0] = f1;
      ref_mem[1] = f2;
      exp_wr.push_back({4'd0, f1});
      exp_wr.push_back({4'd1, f2});
      if (!no_resp) begin
        r = alu_f(f3[3:0], f1, f2);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
      end
    end else if (c == CMD_NOP) begin
      r = alu_f(f1[3:0], ref_mem[0], ref_mem[1]);
      exp_tx.push_back(r[7:0]);
      exp_tx.push_back(r[15:8]);
    end else begin
      exp_err++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.BUSY === 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    check({tag, ":busy_end"}, 32'(bus.BUSY), 0);
    tick(3);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ":tx_n"}, got_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
      check($sformatf("%s:tx%0d", tag, i), 32'(got_tx[i]), 32'(exp_tx[i]));
    check({tag, ":wr_n"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      check($sformatf("%s:wr%0d", tag, i), 32'(got_wr[i]), 32'(exp_wr[i]));
    check({tag, ":rd_n"}, got_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
      check($sformatf("%s:rd%0d", tag, i), 32'(got_rd[i]), 32'(exp_rd[i]));
    check({tag, ":err_n"}, got_err, exp_err);
    got_tx.delete(); exp_tx.delete();
    got_wr.delete(); exp_wr.delete();
    got_rd.delete(); exp_rd.delete();
    got_err = 0;
    exp_err = 0;
  endtask

  task automatic run_cmd(input string tag, input bit no_resp);
    model_cmd(no_resp);
    foreach (cmd_q[i]) begin
      send_frame(cmd_q[i]);
      if (i != cmd_q.size() - 1) tick(int'($urandom_range(0, 2)));
    end
    // A stray frame while the FSM waits for read data must be ignored.
    if (cmd_q[0] == CMD_RD && !no_resp) begin
      tick(1);
      send_frame(CMD_WR);
    end
    wait_idle(tag);
    compare_all(tag);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ":alu_fun"},    32'(bus.ALU_FUN), 0);
    check({tag, ":alu_en"},     32'(bus.ALU_EN), 0);
    check({tag, ":clk_en"},     32'(bus.CLK_EN), 0);
    check({tag, ":addr"},       32'(bus.ADDR), 0);
    check({tag, ":wr_en"},      32'(bus.WR_EN), 0);
    check({tag, ":rd_en"},      32'(bus.RD_EN), 0);
    check({tag, ":wr_data"},    32'(bus.WR_DATA), 0);
    check({tag, ":tx_data"},    32'(bus.TX_P_DATA), 0);
    check({tag, ":tx_vld"},     32'(bus.TX_D_VLD), 0);
    check({tag, ":clk_div_en"}, 32'(bus.CLK_DIV_EN), 1);
    check({tag, ":busy"},       32'(bus.BUSY), 0);
    check({tag, ":err"},        32'(bus.ERR), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] f;
    bus.RX_P_DATA   = '0;
    bus.RX_D_VLD    = 1'b0;
    bus.ALU_OUT     = '0;
    bus.ALU_OUT_VLD = 1'b0;
    bus.RD_DATA     = '0;
    bus.RD_DATA_VLD = 1'b0;
    bus.FIFO_FULL   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end

    // Reset values (FIFO_FULL held high: TX_D_VLD must still be 0 in IDLE).
    @(negedge CLK);
    check_reset("por");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    tick(2);

    // Single register write.
    set_cmd(3, CMD_WR, 8'h05, 8'h3C, 8'h00);
    run_cmd("wr", 0);

    // Single read of 0x5A at address 7, answered two cycles after RD_EN.
    rd_lat = 2;
    set_cmd(3, CMD_WR, 8'h07, 8'h5A, 8'h00);
    run_cmd("wr7", 0);
    set_cmd(2, CMD_RD, 8'h07, 8'h00, 8'h00);
    run_cmd("rd", 0);
    rd_lat = 0;

    // ALU operation with operands, function 0.
    set_cmd(4, CMD_ALU, 8'h10, 8'h20, 8'h00);
    run_cmd("alu", 0);
    check("alu:fun", 32'(bus.ALU_FUN), 0);

    // Burst read wrapping past the top address, FIFO full during 2nd push.
    fifo_mode   = 2;
    stall_armed = 1;
    set_cmd(3, CMD_BRD, 8'h0E, 8'h03, 8'h00);
    run_cmd("brd_wrap", 0);
    fifo_mode   = 0;

    // Illegal command, then burst read with zero count.
    set_cmd(1, 8'h42, 8'h00, 8'h00, 8'h00);
    run_cmd("illegal", 0);
    set_cmd(3, CMD_BRD, 8'h00, 8'h00, 8'h00);
    run_cmd("brd_zero", 0);

    // Read whose data never arrives: timeout ERR.
    rd_mute = 1;
    set_cmd(2, CMD_RD, 8'h03, 8'h00, 8'h00);
    run_cmd("timeout", 1);
    check("timeout:gap", err_cyc - rd_en_cyc, TO_CYC + 1);
    rd_mute = 0;

    // Asynchronous reset while waiting for the ALU.
    alu_mute = 1;
    set_cmd(4, CMD_ALU, 8'h33, 8'h44, 8'h01);
    model_cmd(1);
    foreach (cmd_q[i]) send_frame(cmd_q[i]);
    tick(5);
    check("rst:alu_en_pre", 32'(bus.ALU_EN), 1);
    check("rst:busy_pre",   32'(bus.BUSY), 1);
    RST = 1'b0;
    @(negedge CLK);
    check_reset("rst");
    @(posedge CLK);
    #1;
    check_reset("rst_edge");
    RST       = 1'b1;
    alu_mute  = 0;
    alu_delay = 0;
    tick(3);
    compare_all("rst");

    // Randomized command stream with random FIFO back-pressure.
    fifo_mode = 1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: set_cmd(3, CMD_WR, 8'($urandom), 8'($urandom), 8'h00);
        1: set_cmd(2, CMD_RD, 8'($urandom), 8'h00, 8'h00);
        2: set_cmd(3, CMD_BRD, 8'($urandom), 8'($urandom_range(0, 5)), 8'h00);
        3: set_cmd(4, CMD_ALU, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 5)));
        4: set_cmd(2, CMD_NOP, 8'($urandom_range(0, 5)), 8'h00, 8'h00);
        default: begin
          f = 8'($urandom);
          while (f == CMD_WR || f == CMD_RD || f == CMD_ALU || f == CMD_NOP || f == CMD_BRD)
            f = 8'($urandom);
          set_cmd(1, f, 8'h00, 8'h00, 8'h00);
        end
      endcase
      run_cmd($sformatf("rnd%0d", k), 0);
    end
    fifo_mode = 0;

    check("no_push_while_full", full_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
